// File: rtl/ifetch_pkg.sv
// Shared constants and types for the prefetching instruction fetch unit.
package ifetch_pkg;

    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    localparam int unsigned PC_INC     = 4;

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        BR_WAIT
    } fetch_state_t;

    // Pre-decode: conditional branches share one opcode, funct3 is irrelevant.
    function automatic logic is_branch(input logic [6:0] opcode);
        return opcode == OPC_BRANCH;
    endfunction

endpackage

// File: rtl/inst_fifo.sv
// Synchronous FIFO holding {instruction, pc} pairs; head entry is registered state.
module inst_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // Storage, wrapping pointers and occupancy; storage cleared so the head reads zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                storage[i] <= '0;
            end
        end else begin
            if (push) begin
                storage[wr_ptr] <= push_data;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head_data = storage[rd_ptr];

endmodule

// File: rtl/i_fetch_queue.sv
// Prefetching fetch unit: one request in flight, DEPTH-entry buffer, stops at branches.
module i_fetch_queue
    import ifetch_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           INST_WIDTH = 32,
    parameter int unsigned           DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  mem_valid,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_done,
    input  logic [INST_WIDTH-1:0] mem_inst,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [INST_WIDTH-1:0] inst,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_offset
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fetch_state_t          state, state_next;
    logic [ADDR_WIDTH-1:0] pc, pc_next;
    logic [ADDR_WIDTH-1:0] br_pc, br_pc_next;
    logic                  req, req_next;

    logic [CW-1:0]         count;
    logic [CW-1:0]         count_after;
    logic                  push;
    logic                  pop;
    logic                  room;
    logic [INST_WIDTH+ADDR_WIDTH-1:0] head;

    assign mem_valid  = req;
    assign mem_addr   = pc;
    assign push       = req && mem_done;
    assign pop        = inst_valid && inst_ready;
    assign inst_valid = (count != '0);

    // Room for a new request is judged on the occupancy after this edge's push/pop.
    assign count_after = count + CW'(push) - CW'(pop);
    assign room        = (count_after < CW'(DEPTH));

    inst_fifo #(
        .WIDTH (INST_WIDTH + ADDR_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({mem_inst, pc}),
        .pop       (pop),
        .head_data (head),
        .count     (count)
    );

    assign inst    = head[INST_WIDTH+ADDR_WIDTH-1:ADDR_WIDTH];
    assign inst_pc = head[ADDR_WIDTH-1:0];

    // Fetch state, pc, branch pc and request flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
            pc    <= RESET_PC;
            br_pc <= '0;
            req   <= 1'b0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            br_pc <= br_pc_next;
            req   <= req_next;
        end
    end

    // Next-state logic: issue, complete, hold for room, wait for branch redirect.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        br_pc_next = br_pc;
        req_next   = req;
        case (state)
            FETCH: begin
                if (!req) begin
                    // Only reachable right after reset: raise the first request.
                    if (room) req_next = 1'b1;
                    else      state_next = HOLD;
                end else if (mem_done) begin
                    if (is_branch(mem_inst[6:0])) begin
                        br_pc_next = pc;
                        state_next = BR_WAIT;
                        req_next   = 1'b0;
                    end else begin
                        pc_next = pc + ADDR_WIDTH'(PC_INC);
                        if (!room) begin
                            state_next = HOLD;
                            req_next   = 1'b0;
                        end
                    end
                end
            end
            HOLD: begin
                if (room) begin
                    state_next = FETCH;
                    req_next   = 1'b1;
                end
            end
            BR_WAIT: begin
                if (redirect_valid) begin
                    pc_next = br_pc + redirect_offset;
                    if (room) begin
                        state_next = FETCH;
                        req_next   = 1'b1;
                    end else begin
                        state_next = HOLD;
                    end
                end
            end
            default: begin
                state_next = FETCH;
                req_next   = 1'b0;
            end
        endcase
    end

endmodule
